wb_merge: RTL and testbench

Write-back merge stage for the TPU backend. It collects results from the two execution lanes, integer (INT) and floating-point (FP), and issues at most one write-back per cycle on a single registered stream. That stream drives the register-file write port and the write-back inputs (`I_WB_Index`/`I_WB_Data`) of the bypass buffer. Each lane has a small queue, so both lanes can complete in the same cycle without loss.

---
 rtl/pkg_tpu.sv | 21 ++
 rtl/wb_lane_queue.sv | 61 ++++++
 rtl/wb_merge.sv | 78 +++++++
 tb/tb_wb_merge.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pkg_tpu.sv
// Shared TPU backend types: register destinations, data words and write-back entries.
package pkg_tpu;
  localparam int IDX_W          = 5;
  localparam int DATA_W         = 32;
  localparam int WB_QUEUE_DEPTH = 4;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic v;
    idx_t idx;
  } dst_t;

  typedef struct packed {
    idx_t  idx;
    data_t data;
  } wb_ent_t;

  typedef enum logic {LANE_INT = 1'b0, LANE_FP = 1'b1} lane_e;
endpackage

// File: rtl/wb_lane_queue.sv
// Per-lane write-back FIFO; an empty queue presents the same-cycle input as its head.
module wb_lane_queue
  import pkg_tpu::*;
#(
  parameter int DEPTH = WB_QUEUE_DEPTH
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    in_v_i,
  input  wb_ent_t in_ent_i,
  input  logic    grant_i,
  output logic    cand_v_o,
  output wb_ent_t cand_o,
  output logic    full_o,
  output logic    drop_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_ent_t        mem_q [DEPTH];
  logic [PW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           full_q;
  logic           empty, at_cap, pop, bypass, push;

  assign empty    = (cnt_q == '0);
  assign at_cap   = (cnt_q == CW'(DEPTH));
  assign cand_v_o = !empty || in_v_i;
  assign cand_o   = empty ? in_ent_i : mem_q[rd_q];

  // A grant on an empty queue consumes the input directly, so nothing is stored.
  assign pop    = grant_i && !empty;
  assign bypass = grant_i && empty;
  assign push   = in_v_i && !bypass && (!at_cap || pop);
  assign drop_o = in_v_i && at_cap && !pop;
  assign full_o = full_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      cnt_q  <= cnt_d;
      full_q <= (cnt_d >= CW'(DEPTH - 1));
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= in_ent_i;
  end
endmodule

// File: rtl/wb_merge.sv
// Merges INT and FP lane results into one registered write-back stream, round-robin.
module wb_merge
  import pkg_tpu::*;
#(
  parameter int QUEUE_DEPTH = WB_QUEUE_DEPTH
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  I_Stall,
  input  dst_t  I_INT_WB_Index,
  input  data_t I_INT_WB_Data,
  input  dst_t  I_FP_WB_Index,
  input  data_t I_FP_WB_Data,
  output dst_t  O_WB_Index,
  output data_t O_WB_Data,
  output logic  O_Full_INT,
  output logic  O_Full_FP,
  output logic  O_Overflow
);
  logic [1:0] in_v, cand_v, grant, full, drop;
  wb_ent_t    in_ent [2];
  wb_ent_t    cand   [2];
  lane_e      last_q;
  dst_t       wb_idx_q;
  data_t      wb_data_q;
  logic       ovf_q;

  assign in_v[LANE_INT]   = I_INT_WB_Index.v;
  assign in_v[LANE_FP]    = I_FP_WB_Index.v;
  assign in_ent[LANE_INT] = '{idx: I_INT_WB_Index.idx, data: I_INT_WB_Data};
  assign in_ent[LANE_FP]  = '{idx: I_FP_WB_Index.idx,  data: I_FP_WB_Data};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    wb_lane_queue #(.DEPTH(QUEUE_DEPTH)) u_q (
      .clock    (clock),
      .reset    (reset),
      .in_v_i   (in_v[g]),
      .in_ent_i (in_ent[g]),
      .grant_i  (grant[g]),
      .cand_v_o (cand_v[g]),
      .cand_o   (cand[g]),
      .full_o   (full[g]),
      .drop_o   (drop[g])
    );
  end

  // FP wins a contested cycle only if INT was granted last.
  assign grant[LANE_FP]  = !I_Stall && cand_v[LANE_FP] &&
                           (!cand_v[LANE_INT] || last_q == LANE_INT);
  assign grant[LANE_INT] = !I_Stall && cand_v[LANE_INT] && !grant[LANE_FP];

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_idx_q  <= '0;
      wb_data_q <= '0;
      ovf_q     <= 1'b0;
      last_q    <= LANE_INT;
    end else begin
      wb_idx_q.v <= |grant;
      if (grant[LANE_FP]) begin
        wb_idx_q.idx <= cand[LANE_FP].idx;
        wb_data_q    <= cand[LANE_FP].data;
        last_q       <= LANE_FP;
      end else if (grant[LANE_INT]) begin
        wb_idx_q.idx <= cand[LANE_INT].idx;
        wb_data_q    <= cand[LANE_INT].data;
        last_q       <= LANE_INT;
      end
      ovf_q <= ovf_q || (|drop);
    end
  end

  assign O_WB_Index = wb_idx_q;
  assign O_WB_Data  = wb_data_q;
  assign O_Full_INT = full[LANE_INT];
  assign O_Full_FP  = full[LANE_FP];
  assign O_Overflow = ovf_q;
endmodule

// File: tb/tb_wb_merge.sv
// Directed bench for wb_merge: vector table plus a hand-written reset sequence.
module tb_wb_merge;
  import pkg_tpu::*;

  logic  clock, reset, I_Stall;
  dst_t  I_INT_WB_Index, I_FP_WB_Index, O_WB_Index;
  data_t I_INT_WB_Data, I_FP_WB_Data, O_WB_Data;
  logic  O_Full_INT, O_Full_FP, O_Overflow;

  int n_run  = 0;
  int n_fail = 0;

  wb_merge #(.QUEUE_DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .I_Stall        (I_Stall),
    .I_INT_WB_Index (I_INT_WB_Index),
    .I_INT_WB_Data  (I_INT_WB_Data),
    .I_FP_WB_Index  (I_FP_WB_Index),
    .I_FP_WB_Data   (I_FP_WB_Data),
    .O_WB_Index     (O_WB_Index),
    .O_WB_Data      (O_WB_Data),
    .O_Full_INT     (O_Full_INT),
    .O_Full_FP      (O_Full_FP),
    .O_Overflow     (O_Overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          rst, stall, iv;
    int          ii;
    logic [31:0] id;
    bit          fv;
    int          fi;
    logic [31:0] fd;
    bit          ev;
    int          ei;
    logic [31:0] ed;
    bit          efi, eff, eov;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t V(bit rst, bit stall, bit iv, int ii, logic [31:0] id,
                             bit fv, int fi, logic [31:0] fd, bit ev, int ei,
                             logic [31:0] ed, bit efi, bit eff, bit eov);
    vec_t r;
    r.rst = rst; r.stall = stall; r.iv = iv; r.ii = ii; r.id = id;
    r.fv = fv; r.fi = fi; r.fd = fd; r.ev = ev; r.ei = ei; r.ed = ed;
    r.efi = efi; r.eff = eff; r.eov = eov;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit stall, input bit iv, input int ii,
                       input logic [31:0] id, input bit fv, input int fi, input logic [31:0] fd);
    reset              = rst;
    I_Stall            = stall;
    I_INT_WB_Index.v   = iv;
    I_INT_WB_Index.idx = idx_t'(ii);
    I_INT_WB_Data      = id;
    I_FP_WB_Index.v    = fv;
    I_FP_WB_Index.idx  = idx_t'(fi);
    I_FP_WB_Data       = fd;
  endtask

  initial begin
    // Single results on each lane, then 4 cycles of dual-lane traffic (last grant FP -> INT first)
    vq.push_back(V(0,0, 1,5,32'hA5, 0,0,0,     1,5,32'hA5, 0,0,0));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     0,0,32'hA5, 0,0,0));
    vq.push_back(V(0,0, 0,0,0,      1,7,32'h77,1,7,32'h77, 0,0,0));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     0,0,32'h77, 0,0,0));
    vq.push_back(V(0,0, 1,1,32'h10, 1,2,32'h20,1,1,32'h10, 0,0,0));
    vq.push_back(V(0,0, 1,1,32'h11, 1,2,32'h21,1,2,32'h20, 0,0,0));
    vq.push_back(V(0,0, 1,1,32'h12, 1,2,32'h22,1,1,32'h11, 0,0,0));
    vq.push_back(V(0,0, 1,1,32'h13, 1,2,32'h23,1,2,32'h21, 0,0,0));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     1,1,32'h12, 0,0,0));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     1,2,32'h22, 0,0,0));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     1,1,32'h13, 0,0,0));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     1,2,32'h23, 0,0,0));
    // Stall 3 INT pushes, then drain
    vq.push_back(V(0,1, 1,3,32'h30, 0,0,0,     0,0,32'h23, 0,0,0));
    vq.push_back(V(0,1, 1,3,32'h31, 0,0,0,     0,0,32'h23, 0,0,0));
    vq.push_back(V(0,1, 1,3,32'h32, 0,0,0,     0,0,32'h23, 1,0,0));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     1,3,32'h30, 0,0,0));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     1,3,32'h31, 0,0,0));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     1,3,32'h32, 0,0,0));
    // Overflow: 5 pushes under stall, 5th dropped
    vq.push_back(V(0,1, 1,8,32'h40, 0,0,0,     0,0,32'h32, 0,0,0));
    vq.push_back(V(0,1, 1,8,32'h41, 0,0,0,     0,0,32'h32, 0,0,0));
    vq.push_back(V(0,1, 1,8,32'h42, 0,0,0,     0,0,32'h32, 1,0,0));
    vq.push_back(V(0,1, 1,8,32'h43, 0,0,0,     0,0,32'h32, 1,0,0));
    vq.push_back(V(0,1, 1,8,32'h44, 0,0,0,     0,0,32'h32, 1,0,1));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     1,8,32'h40, 1,0,1));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     1,8,32'h41, 0,0,1));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     1,8,32'h42, 0,0,1));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     1,8,32'h43, 0,0,1));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     0,0,32'h43, 0,0,1));
    // Reset clears the sticky overflow
    vq.push_back(V(1,0, 0,0,0,      0,0,0,     0,0,32'h0,  0,0,0));
    // Fill to 4, push+pop while full, pointer wrap on both sides
    vq.push_back(V(0,1, 1,9,32'h50, 0,0,0,     0,0,32'h0,  0,0,0));
    vq.push_back(V(0,1, 1,9,32'h51, 0,0,0,     0,0,32'h0,  0,0,0));
    vq.push_back(V(0,1, 1,9,32'h52, 0,0,0,     0,0,32'h0,  1,0,0));
    vq.push_back(V(0,1, 1,9,32'h53, 0,0,0,     0,0,32'h0,  1,0,0));
    vq.push_back(V(0,0, 1,9,32'h54, 0,0,0,     1,9,32'h50, 1,0,0));
    vq.push_back(V(0,0, 1,9,32'h55, 0,0,0,     1,9,32'h51, 1,0,0));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     1,9,32'h52, 1,0,0));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     1,9,32'h53, 0,0,0));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     1,9,32'h54, 0,0,0));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     1,9,32'h55, 0,0,0));
    vq.push_back(V(0,0, 0,0,0,      0,0,0,     0,0,32'h55, 0,0,0));

    drive(1, 0, 0,0,0, 0,0,0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst v",    32'(O_WB_Index.v), 0);
    chk("rst idx",  32'(O_WB_Index.idx), 0);
    chk("rst data", O_WB_Data, 0);
    chk("rst full_int", 32'(O_Full_INT), 0);
    chk("rst full_fp",  32'(O_Full_FP), 0);
    chk("rst ovf",      32'(O_Overflow), 0);

    foreach (vq[k]) begin
      drive(vq[k].rst, vq[k].stall, vq[k].iv, vq[k].ii, vq[k].id, vq[k].fv, vq[k].fi, vq[k].fd);
      @(posedge clock);
      #1;
      chk($sformatf("row%0d v", k), 32'(O_WB_Index.v), 32'(vq[k].ev));
      if (vq[k].ev) chk($sformatf("row%0d idx", k), 32'(O_WB_Index.idx), vq[k].ei);
      chk($sformatf("row%0d data", k), O_WB_Data, vq[k].ed);
      chk($sformatf("row%0d full_int", k), 32'(O_Full_INT), 32'(vq[k].efi));
      chk($sformatf("row%0d full_fp", k),  32'(O_Full_FP),  32'(vq[k].eff));
      chk($sformatf("row%0d ovf", k),      32'(O_Overflow), 32'(vq[k].eov));
    end

    // Reset with 3 INT entries queued and 1 FP entry queued: nothing stale may issue
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1,10,32'h60 + 32'(i), (i == 0),11,32'h70);
      @(posedge clock);
      #1;
    end
    chk("pre-reset full_int", 32'(O_Full_INT), 1);
    drive(1, 0, 0,0,0, 0,0,0);
    @(posedge clock);
    #1;
    chk("midrst v",        32'(O_WB_Index.v), 0);
    chk("midrst full_int", 32'(O_Full_INT), 0);
    chk("midrst full_fp",  32'(O_Full_FP), 0);
    chk("midrst ovf",      32'(O_Overflow), 0);
    drive(0, 0, 0,0,0, 0,0,0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk($sformatf("postrst%0d v", i), 32'(O_WB_Index.v), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
